// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types, default width and counter sizing for seq_divider
// Optional signed mode selected by SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
`ifdef SEQ_DIVIDER_SIGNED_EN
        S_FIXUP = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    // Enough bits to hold the step count 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division iteration
// Shifts in the next dividend bit, trial-subtracts the divisor, keeps or restores.
module div_restore_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, msb_in};
    assign diff    = shifted - {1'b0, divisor};
    // Top bit of the WIDTH+1 difference is the borrow: clear means it fit.
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP state).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dd_load;
    logic [WIDTH-1:0] dv_load;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             dz;
    logic             last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg;
    logic r_neg;

    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
    assign dd_load = (Divisor == '0 || !Dividend[WIDTH-1]) ? Dividend
                                                           : {WIDTH{1'b0}} - Dividend;
    assign dv_load = Divisor[WIDTH-1] ? {WIDTH{1'b0}} - Divisor : Divisor;
`else
    assign dd_load = Dividend;
    assign dv_load = Divisor;
`endif

    assign Busy      = (state != S_IDLE);
    assign last_step = (cnt == CW'(WIDTH - 1));

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .msb_in  (dq[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = (Divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_nxt = S_FIXUP;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            S_FIXUP: state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // dq starts as the dividend and fills with quotient bits as it shifts left.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt       <= '0;
            dq        <= '0;
            dvs       <= '0;
            rem       <= '0;
            dz        <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        dq        <= dd_load;
                        dvs       <= dv_load;
                        rem       <= '0;
                        cnt       <= '0;
                        dz        <= (Divisor == '0);
                        Quotient  <= '0;
                        Remainder <= '0;
                        DivByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_neg     <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                        r_neg     <= Dividend[WIDTH-1];
`endif
                    end
                end
                S_CALC: begin
                    rem <= step_rem;
                    dq  <= {dq[WIDTH-2:0], step_q};
                    cnt <= cnt + CW'(1);
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                S_FIXUP: begin
                    if (q_neg) dq  <= {WIDTH{1'b0}} - dq;
                    if (r_neg) rem <= {WIDTH{1'b0}} - rem;
                end
`endif
                S_DONE: begin
                    Done      <= 1'b1;
                    DivByZero <= dz;
                    Quotient  <= dz ? {WIDTH{1'b1}} : dq;
                    Remainder <= dz ? dq : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (signed cases under SEQ_DIVIDER_SIGNED_EN)
module tb_seq_divider;

    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivByZero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t        m;
        logic [31:0] tq;
        logic [31:0] tr;
`ifdef SEQ_DIVIDER_SIGNED_EN
        int a;
        int b;
        a = int'($signed(dd));
        b = int'($signed(dv));
        m.lat = W + 2;
        if (b != 0) begin
            tq = a / b;
            tr = a % b;
        end else begin
            tq = '0;
            tr = '0;
        end
`else
        m.lat = W + 1;
        if (dv != 0) begin
            tq = 32'(dd) / 32'(dv);
            tr = 32'(dd) % 32'(dv);
        end else begin
            tq = '0;
            tr = '0;
        end
`endif
        if (dv == 0) begin
            m.q   = '1;
            m.r   = dd;
            m.dz  = 1'b1;
            m.lat = 1;
        end else begin
            m.q  = tq[W-1:0];
            m.r  = tr[W-1:0];
            m.dz = 1'b0;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered with Start already high before the accepting edge.
    task automatic accept_and_wait(input string tag, input bit start_in_done);
        exp_t e;
        int   n;
        int   lat;
        lat = sb[0].lat;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        chk({tag, "_busy"},     32'(Busy), 32'(1));
        chk({tag, "_q_clear"},  32'(Quotient), 32'(0));
        chk({tag, "_r_clear"},  32'(Remainder), 32'(0));
        chk({tag, "_dz_clear"}, 32'(DivByZero), 32'(0));
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            if (start_in_done && n == lat - 1) begin
                Start    = 1'b1;
                Dividend = '0;
                Divisor  = '0;
            end
            @(posedge Clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"},   32'(n), 32'(e.lat));
        chk({tag, "_quotient"},  32'(Quotient), 32'(e.q));
        chk({tag, "_remainder"}, 32'(Remainder), 32'(e.r));
        chk({tag, "_divbyzero"}, 32'(DivByZero), 32'(e.dz));
        chk({tag, "_idle"},      32'(Busy), 32'(0));
    endtask

    task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
        Dividend = dd;
        Divisor  = dv;
        Start    = 1'b1;
        sb.push_back(model(dd, dv));
    endtask

    task automatic run(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv);
        @(negedge Clk);
        launch(dd, dv);
        accept_and_wait(tag, 1'b0);
    endtask

    initial begin
        Rst_n    = 1'b0;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_done", 32'(Done), 32'(0));
        chk("rst_q",    32'(Quotient), 32'(0));
        chk("rst_r",    32'(Remainder), 32'(0));
        chk("rst_dz",   32'(DivByZero), 32'(0));

        // Start presented on the very first edge after reset release.
        Rst_n = 1'b1;
        launch(8'd100, 8'd7);
        accept_and_wait("d100_7", 1'b0);

        // 255/1, Start held through DONE with junk, then 5/9 back-to-back.
        @(negedge Clk);
        launch(8'd255, 8'd1);
        accept_and_wait("d255_1", 1'b1);
        launch(8'd5, 8'd9);
        accept_and_wait("d5_9", 1'b0);

        run("d13_0", 8'd13, 8'd0);
        run("d6_3", 8'd6, 8'd3);

        // Abort 200/3 with an asynchronous reset between clock edges.
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd3;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(Busy), 32'(0));
        chk("arst_done", 32'(Done), 32'(0));
        chk("arst_q",    32'(Quotient), 32'(0));
        chk("arst_r",    32'(Remainder), 32'(0));
        chk("arst_dz",   32'(DivByZero), 32'(0));
        @(negedge Clk);
        Rst_n = 1'b1;
        run("d200_3", 8'd200, 8'd3);

        for (int i = 0; i < 4; i++) begin
            run("rand", W'($urandom), W'($urandom_range(1, 255)));
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        run("s_m100_7", 8'h9C, 8'd7);
        run("s_m128_m1", 8'h80, 8'hFF);
        run("s_m5_0", 8'hFB, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
